// File: rtl/edge_detect_pkg.sv
// Shared types and constants for the multi-channel edge detector.
package edge_detect_pkg;

    // Per-channel debounce/edge FSM states
    typedef enum logic [2:0] {
        LOW        = 3'd0,
        RISE_CHK   = 3'd1,
        RISE_PULSE = 3'd2,
        HIGH       = 3'd3,
        FALL_CHK   = 3'd4,
        FALL_PULSE = 3'd5
    } edge_state_t;

    // Per-channel 2-bit mode field: bit0 enables rise events, bit1 fall events
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // True when the mode field lets rising edges through
    function automatic logic rise_enabled(input logic [1:0] m);
        return (m & MODE_RISE) != MODE_OFF;
    endfunction

    // True when the mode field lets falling edges through
    function automatic logic fall_enabled(input logic [1:0] m);
        return (m & MODE_FALL) != MODE_OFF;
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchroniser, debounce FSM with counter, Moore level/edge decode.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    edge_state_t            state;
    edge_state_t            state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;

    // Synchroniser chain; only its last stage feeds the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // State and debounce counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: a change must persist for DEBOUNCE samples after the first
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            LOW: begin
                if (s) begin
                    state_next = RISE_CHK;
                    cnt_next   = CNT_ONE;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_next = LOW;
                end else if (cnt >= CNT_MAX) begin
                    state_next = RISE_PULSE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RISE_PULSE: begin
                state_next = HIGH;
            end
            HIGH: begin
                if (!s) begin
                    state_next = FALL_CHK;
                    cnt_next   = CNT_ONE;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_next = HIGH;
                end else if (cnt >= CNT_MAX) begin
                    state_next = FALL_PULSE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            FALL_PULSE: begin
                state_next = LOW;
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Moore decode of level and raw edge pulses from the state register
    always_comb begin
        level = (state == RISE_PULSE) || (state == HIGH) || (state == FALL_CHK);
        rise  = (state == RISE_PULSE);
        fall  = (state == FALL_PULSE);
    end

endmodule

// File: rtl/edge_detect_multi.sv
// N_CH debounced edge detectors with per-channel mode gating, sticky flags and IRQ.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    input  logic [N_CH-1:0]   irq_en,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   evt,
    output logic [N_CH-1:0]   sticky,
    output logic              irq
);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] sticky_next;

    // Independent channel instances; mode only gates the event, never the FSM
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_detect_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );

        assign evt[i] = (rise[i] && rise_enabled(mode[2*i +: 2]))
                     || (fall[i] && fall_enabled(mode[2*i +: 2]));
    end

    // Set beats clear when both happen in the same cycle
    always_comb begin
        sticky_next = (sticky & ~clr) | evt;
    end

    // Sticky flags and interrupt both follow sticky_next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
            irq    <= 1'b0;
        end else begin
            sticky <= sticky_next;
            irq    <= |(sticky_next & irq_en);
        end
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised self-checking bench for edge_detect_multi against a run-length model.
module tb_edge_detect_multi;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DB = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] din;
    logic [2*N-1:0] mode;
    logic [N-1:0] clr;
    logic [N-1:0] irq_en;
    logic [N-1:0] level;
    logic [N-1:0] evt;
    logic [N-1:0] sticky;
    logic         irq;

    int n_chk;
    int n_bad;

    // Reference model: input delay line, accepted level, length of current disagreement
    bit           m_pipe [N][SS];
    bit           m_lvl  [N];
    int           m_run  [N];
    bit           m_pulse_r [N];
    bit           m_pulse_f [N];
    bit           m_quiet [N];
    bit [N-1:0]   m_sticky;
    bit           m_irq;
    int           hold_left [N];

    edge_detect_multi #(
        .N_CH        (N),
        .SYNC_STAGES (SS),
        .DEBOUNCE    (DB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (din),
        .mode   (mode),
        .clr    (clr),
        .irq_en (irq_en),
        .level  (level),
        .evt    (evt),
        .sticky (sticky),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit [N-1:0] exp_evt();
        bit [N-1:0] e;
        for (int i = 0; i < N; i++) begin
            e[i] = (m_pulse_r[i] && mode[2*i]) || (m_pulse_f[i] && mode[2*i+1]);
        end
        return e;
    endfunction

    function automatic bit [N-1:0] exp_level();
        bit [N-1:0] l;
        for (int i = 0; i < N; i++) l[i] = m_lvl[i];
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < SS; k++) m_pipe[i][k] = 1'b0;
            m_lvl[i]     = 1'b0;
            m_run[i]     = 0;
            m_pulse_r[i] = 1'b0;
            m_pulse_f[i] = 1'b0;
            m_quiet[i]   = 1'b0;
        end
        m_sticky = '0;
        m_irq    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge
    task automatic model_step();
        bit [N-1:0] e;
        bit         s;
        e        = exp_evt();
        m_sticky = (m_sticky & ~clr) | e;
        m_irq    = |(m_sticky & irq_en);
        for (int i = 0; i < N; i++) begin
            s = m_pipe[i][SS-1];
            for (int k = SS-1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
            m_pipe[i][0] = din[i];
            if (m_quiet[i]) begin
                // Cycle of the event pulse: input is not looked at
                m_quiet[i]   = 1'b0;
                m_pulse_r[i] = 1'b0;
                m_pulse_f[i] = 1'b0;
            end else if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB + 1) begin
                    m_lvl[i]     = s;
                    m_pulse_r[i] = s;
                    m_pulse_f[i] = !s;
                    m_quiet[i]   = 1'b1;
                    m_run[i]     = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string phase);
        chk({phase, "_level"},  32'(level),  32'(exp_level()));
        chk({phase, "_evt"},    32'(evt),    32'(exp_evt()));
        chk({phase, "_sticky"}, 32'(sticky), 32'(m_sticky));
        chk({phase, "_irq"},    32'(irq),    32'(m_irq));
    endtask

    // Asynchronous reset in the middle of activity; release on a falling edge
    task automatic mid_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_level",  32'(level),  32'd0);
        chk("midrst_evt",    32'(evt),    32'd0);
        chk("midrst_sticky", 32'(sticky), 32'd0);
        chk("midrst_irq",    32'(irq),    32'd0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        din    = 4'b1111;
        mode   = 8'hFF;
        clr    = '0;
        irq_en = '0;
        model_reset();
        for (int i = 0; i < N; i++) hold_left[i] = 1;

        // Inputs high through reset: outputs stay 0, then all channels rise at edge 7
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",  32'(level),  32'd0);
        chk("rst_evt",    32'(evt),    32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_irq",    32'(irq),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check_all("boot");
            chk("boot_evt_edge",   32'(evt),    (k == SS + DB + 1) ? 32'hF : 32'h0);
            chk("boot_level_edge", 32'(level),  (k >= SS + DB + 1) ? 32'hF : 32'h0);
            chk("boot_sticky_edge", 32'(sticky), (k >= SS + DB + 2) ? 32'hF : 32'h0);
        end

        // Randomised run: mixed hold lengths give both glitches and real edges
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                hold_left[i]--;
                if (hold_left[i] <= 0) begin
                    din[i]       = ~din[i];
                    hold_left[i] = int'($urandom_range(1, 14));
                end
            end
            clr = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) irq_en = N'($urandom);
            if ($urandom_range(0, 99) == 0) mode = 8'($urandom);

            @(posedge clk);
            model_step();
            #1;
            check_all("rnd");

            if (cyc % 700 == 699) begin
                mid_reset(int'($urandom_range(1, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
